useq: RTL and testbench
=======================

# useq

Microprogram sequencer for the PDUA control unit, directly downstream of the instruction register. Takes the 5-bit opcode from the IR, ALU flags, and control bits fed back from the microcode ROM, and produces the registered microcode ROM address. Sequences the fetch, execute and interrupt microroutines, handles conditional micro-branches, and traps illegal opcodes and microstep overflow into a sticky halt state.

## Interface
- OP_WIDTH, 5, opcode width; also the page field of the micro-address.
- STEP_WIDTH, 3, micro-step field width; a page holds 8 steps.
- FETCH_PAGE, 5'h1F, page holding the fetch microroutine; illegal as an opcode.
- INT_PAGE, 5'h1E, page holding the interrupt microroutine; illegal as an opcode.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  when high, all state is frozen for that cycle.
- opcode  in  OP_WIDTH  current IR opcode field.
- flags  in  4  {n, z, c, p}, indices 3..0.
- mi_end  in  1  microinstruction is the last of its routine.
- mi_cond_en  in  1  microinstruction is a conditional branch.
- mi_cond_sel  in  2  flag index to test.
- mi_cond_pol  in  1  branch taken when the selected flag equals this value.
- mi_jmp_step  in  STEP_WIDTH  branch target step within the current page.
- int_req  in  1  level interrupt request.
- int_en  in  1  global interrupt enable.
- uaddr  out  OP_WIDTH+STEP_WIDTH  microcode ROM address {page, step}.
- in_fetch  out  1  high while the FETCH routine is active.
- int_ack  out  1  one-cycle pulse on entry to the INT routine.
- halted  out  1  sticky halt.
- illegal  out  1  sticky; high when the halt was caused by an illegal opcode.

## Operation
- States: FETCH, EXEC, INT, HALT.
- uaddr = {page, step}. Both fields are registered outputs, not decoded.
- Reset values:
  - state = FETCH, page = FETCH_PAGE, step = 0, so uaddr = 8'hF8.
  - in_fetch = 1; int_ack, halted and illegal = 0.
- Next-step priority, evaluated each non-stalled cycle in FETCH, EXEC or INT:
  1. mi_end high:
     - FETCH: if opcode is FETCH_PAGE or INT_PAGE, go to HALT with illegal = 1. Otherwise go to EXEC with page = opcode, step = 0.
     - EXEC: if int_req and int_en are both high, go to INT with page = INT_PAGE, step = 0, and pulse int_ack. Otherwise go to FETCH with page = FETCH_PAGE, step = 0.
     - INT: go to FETCH with page = FETCH_PAGE, step = 0.
  2. mi_cond_en high and flags[mi_cond_sel] == mi_cond_pol: step = mi_jmp_step; page unchanged.
  3. Otherwise: step = step + 1.
- Overflow: if step = 7 and neither rule 1 nor a taken rule-2 branch applies, go to HALT with illegal = 0. Step never wraps to 0.
- HALT:
  - uaddr holds its last value.
  - halted = 1.
  - All micro-control inputs and int_req are ignored.
  - Only rst exits HALT.
- mi_end overrides a simultaneous taken branch.
- A branch to the current step is legal; it is the wait-loop idiom.
- int_req is sampled only at an EXEC mi_end. Interrupts are never taken from FETCH or INT, so interrupts do not nest.
- stall:
  - Freezes state, page, step, halted and illegal.
  - Forces int_ack low.
  - rst overrides stall.

## Timing
- One micro-step per clock. uaddr changes on the clock edge after the microinstruction that selected it is presented. The ROM is asynchronous-read: mi_* inputs are combinational functions of uaddr in the same cycle.
- opcode must be stable during the cycle in which FETCH's mi_end is high. The IR load microinstruction must be a strictly earlier step.
- int_ack is high exactly during the first cycle uaddr = {INT_PAGE, 0}. It stays low if that cycle is stalled; the pulse is then emitted on the first non-stalled cycle.
- in_fetch is registered and equals (state == FETCH).
- halted and illegal rise in the same cycle state becomes HALT.
- rst asserted mid-routine or in HALT: on the next edge, all outputs take their reset values.

## Structure
- Shared package pdua_pkg holds:
  - the state enum (FETCH, EXEC, INT, HALT);
  - FETCH_PAGE and INT_PAGE constants;
  - flag index constants N = 3, Z = 2, C = 1, P = 0.
- One sub-module, useq_cond: combinational flag mux plus polarity compare, producing the branch-taken signal. It is reused by the future macro-branch unit.
- The remaining logic (state register, next-address mux, sticky flags) lives in useq.

## Test plan
- Reset, then FETCH steps 0..2 with mi_end at step 2 and opcode = 5'h03 -> uaddr sequence F8, F9, FA, 18; in_fetch falls on the edge that shows uaddr 18.
- In EXEC page 3 at step 1: mi_cond_en = 1, sel = Z, pol = 1, flags = 4'b0100, jmp = 5 -> uaddr 1D. Same stimulus with flags = 0 -> uaddr 1A.
- EXEC mi_end with int_req = 1 and int_en = 1 -> uaddr F0 with int_ack high for exactly one cycle. INT mi_end with int_req still high -> uaddr F8, no second int_ack.
- FETCH mi_end with opcode = 5'h1F, and separately with 5'h1E -> halted = 1, illegal = 1; uaddr frozen for 20 further cycles of toggling inputs.
- EXEC run to step 7 with no mi_end -> halted = 1, illegal = 0. Then rst for one cycle -> uaddr F8, halted = 0.
- stall held for 3 cycles while mi_end and int_req are high in EXEC -> uaddr unchanged and int_ack low throughout. First cycle after stall drops -> uaddr F0 with int_ack pulse.

Source files
------------

// File: rtl/pdua_pkg.sv
// pdua_pkg: shared PDUA control-unit types and constants
package pdua_pkg;
  localparam int OP_WIDTH = 5;
  localparam int STEP_WIDTH = 3;
  localparam logic [OP_WIDTH-1:0] FETCH_PAGE = 5'h1F;
  localparam logic [OP_WIDTH-1:0] INT_PAGE = 5'h1E;
  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int P = 0;
  typedef enum logic [1:0] {FETCH, EXEC, INT, HALT} state_t;
endpackage

// File: rtl/useq_if.sv
// useq_if: microprogram sequencer control and address bundle
interface useq_if;
  import pdua_pkg::*;
  logic stall;
  logic [OP_WIDTH-1:0] opcode;
  logic [3:0] flags;
  logic mi_end;
  logic mi_cond_en;
  logic [1:0] mi_cond_sel;
  logic mi_cond_pol;
  logic [STEP_WIDTH-1:0] mi_jmp_step;
  logic int_req;
  logic int_en;
  logic [OP_WIDTH+STEP_WIDTH-1:0] uaddr;
  logic in_fetch;
  logic int_ack;
  logic halted;
  logic illegal;
  modport master (
    output stall, opcode, flags, mi_end, mi_cond_en, mi_cond_sel, mi_cond_pol, mi_jmp_step, int_req, int_en,
    input uaddr, in_fetch, int_ack, halted, illegal
  );
  modport slave (
    input stall, opcode, flags, mi_end, mi_cond_en, mi_cond_sel, mi_cond_pol, mi_jmp_step, int_req, int_en,
    output uaddr, in_fetch, int_ack, halted, illegal
  );
endinterface

// File: rtl/useq_cond.sv
// useq_cond: flag select and polarity compare giving branch-taken
module useq_cond (
  input  logic [3:0] flags,
  input  logic [1:0] sel,
  input  logic       pol,
  input  logic       en,
  output logic       taken
);
  assign taken = en && (flags[sel] == pol);
endmodule

// File: rtl/useq.sv
// useq: PDUA microprogram sequencer producing the registered micro-ROM address
module useq
  import pdua_pkg::*;
(
  input logic clk,
  input logic rst,
  useq_if.slave bus
);
  state_t state, state_n;
  logic [OP_WIDTH-1:0] page, page_n;
  logic [STEP_WIDTH-1:0] step, step_n;
  logic halted, halted_n, illegal, illegal_n, in_fetch, ack_pend, enter_int, taken, run;
  useq_cond u_cond (
    .flags(bus.flags),
    .sel(bus.mi_cond_sel),
    .pol(bus.mi_cond_pol),
    .en(bus.mi_cond_en),
    .taken(taken)
  );
  assign run = !bus.stall && state != HALT;
  always_comb begin
    state_n = state;
    page_n = page;
    step_n = step;
    halted_n = halted;
    illegal_n = illegal;
    enter_int = 1'b0;
    if (run) begin
      if (bus.mi_end) begin
        if (state == FETCH) begin
          if (bus.opcode == FETCH_PAGE || bus.opcode == INT_PAGE) begin
            state_n = HALT;
            halted_n = 1'b1;
            illegal_n = 1'b1;
          end else begin
            state_n = EXEC;
            page_n = bus.opcode;
            step_n = '0;
          end
        end else if (state == EXEC && bus.int_req && bus.int_en) begin
          state_n = INT;
          page_n = INT_PAGE;
          step_n = '0;
          enter_int = 1'b1;
        end else begin
          state_n = FETCH;
          page_n = FETCH_PAGE;
          step_n = '0;
        end
      end else if (taken) begin
        step_n = bus.mi_jmp_step;
      end else if (&step) begin
        state_n = HALT;
        halted_n = 1'b1;
      end else begin
        step_n = step + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      page <= FETCH_PAGE;
      step <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
      in_fetch <= 1'b1;
      ack_pend <= 1'b0;
    end else begin
      state <= state_n;
      page <= page_n;
      step <= step_n;
      halted <= halted_n;
      illegal <= illegal_n;
      in_fetch <= state_n == FETCH;
      ack_pend <= enter_int || (ack_pend && bus.stall);
    end
  end
  // ack waits out a stalled first INT cycle and fires on the first free one
  assign bus.int_ack = ack_pend && !bus.stall;
  assign bus.uaddr = {page, step};
  assign bus.in_fetch = in_fetch;
  assign bus.halted = halted;
  assign bus.illegal = illegal;
endmodule

// File: tb/tb_useq.sv
// tb_useq: directed self-checking bench for the useq sequencer
module tb_useq;
  logic clk, rst;
  int passed = 0;
  int total = 0;
  int fails = 0;
  useq_if bus ();
  useq dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.stall = 0;
    bus.opcode = '0;
    bus.flags = '0;
    bus.mi_end = 0;
    bus.mi_cond_en = 0;
    bus.mi_cond_sel = '0;
    bus.mi_cond_pol = 0;
    bus.mi_jmp_step = '0;
    bus.int_req = 0;
    bus.int_en = 0;
  endtask
  task automatic scramble(input int i);
    bus.mi_end = i[0];
    bus.mi_cond_en = i[1];
    bus.mi_jmp_step = i[2:0];
    bus.flags = i[3:0];
    bus.mi_cond_sel = i[1:0];
    bus.mi_cond_pol = i[2];
    bus.opcode = i[4:0];
    bus.int_req = 1;
    bus.int_en = 1;
  endtask
  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_uaddr", bus.uaddr, 8'hF8);
    chk("rst_in_fetch", bus.in_fetch, 1);
    chk("rst_int_ack", bus.int_ack, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_illegal", bus.illegal, 0);
    tick();
    chk("fetch1", bus.uaddr, 8'hF9);
    tick();
    chk("fetch2", bus.uaddr, 8'hFA);
    bus.opcode = 5'h03;
    bus.mi_end = 1;
    tick();
    chk("exec_entry", bus.uaddr, 8'h18);
    chk("exec_in_fetch", bus.in_fetch, 0);
    bus.mi_end = 0;
    tick();
    chk("exec_step1", bus.uaddr, 8'h19);
    bus.mi_cond_en = 1;
    bus.mi_cond_sel = 2'd2;
    bus.mi_cond_pol = 1;
    bus.flags = 4'b0100;
    bus.mi_jmp_step = 3'd5;
    tick();
    chk("br_taken", bus.uaddr, 8'h1D);
    bus.mi_jmp_step = 3'd1;
    tick();
    chk("br_back", bus.uaddr, 8'h19);
    bus.flags = 4'b0000;
    bus.mi_jmp_step = 3'd5;
    tick();
    chk("br_not_taken", bus.uaddr, 8'h1A);
    bus.flags = 4'b0100;
    bus.mi_cond_sel = 2'd1;
    bus.mi_cond_pol = 0;
    bus.mi_jmp_step = 3'd2;
    tick();
    chk("br_wait_loop", bus.uaddr, 8'h1A);
    bus.mi_jmp_step = 3'd5;
    bus.mi_end = 1;
    bus.int_req = 1;
    bus.int_en = 1;
    tick();
    chk("int_entry", bus.uaddr, 8'hF0);
    chk("int_ack_pulse", bus.int_ack, 1);
    chk("int_in_fetch", bus.in_fetch, 0);
    bus.mi_cond_en = 0;
    bus.mi_end = 0;
    tick();
    chk("int_step1", bus.uaddr, 8'hF1);
    chk("int_ack_drop", bus.int_ack, 0);
    bus.mi_end = 1;
    tick();
    chk("int_exit", bus.uaddr, 8'hF8);
    chk("int_no_reack", bus.int_ack, 0);
    chk("int_exit_fetch", bus.in_fetch, 1);
    tick();
    chk("exec2_entry", bus.uaddr, 8'h18);
    bus.int_en = 0;
    tick();
    chk("int_disabled", bus.uaddr, 8'hF8);
    chk("int_disabled_ack", bus.int_ack, 0);
    tick();
    chk("exec3_entry", bus.uaddr, 8'h18);
    bus.int_en = 1;
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_uaddr", bus.uaddr, 8'h18);
      chk("stall_ack", bus.int_ack, 0);
    end
    bus.stall = 0;
    tick();
    chk("post_stall_int", bus.uaddr, 8'hF0);
    chk("post_stall_ack", bus.int_ack, 1);
    bus.mi_end = 0;
    bus.stall = 1;
    #1;
    chk("ack_masked", bus.int_ack, 0);
    tick();
    chk("ack_stall_uaddr", bus.uaddr, 8'hF0);
    chk("ack_stall_low", bus.int_ack, 0);
    bus.stall = 0;
    #1;
    chk("ack_resume", bus.int_ack, 1);
    tick();
    chk("ack_resume_step", bus.uaddr, 8'hF1);
    chk("ack_resume_drop", bus.int_ack, 0);
    bus.mi_end = 1;
    tick();
    chk("int2_exit", bus.uaddr, 8'hF8);
    bus.int_req = 0;
    bus.int_en = 0;
    tick();
    chk("ovf_entry", bus.uaddr, 8'h18);
    bus.mi_end = 0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("ovf_walk", bus.uaddr, 8'h18 + k);
    end
    chk("ovf_not_yet", bus.halted, 0);
    tick();
    chk("ovf_halted", bus.halted, 1);
    chk("ovf_illegal", bus.illegal, 0);
    chk("ovf_uaddr", bus.uaddr, 8'h1F);
    chk("ovf_in_fetch", bus.in_fetch, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst2_uaddr", bus.uaddr, 8'hF8);
    chk("rst2_halted", bus.halted, 0);
    chk("rst2_in_fetch", bus.in_fetch, 1);
    bus.opcode = 5'h1F;
    bus.mi_end = 1;
    tick();
    chk("ill1f_halted", bus.halted, 1);
    chk("ill1f_illegal", bus.illegal, 1);
    chk("ill1f_uaddr", bus.uaddr, 8'hF8);
    for (int i = 0; i < 20; i++) begin
      scramble(i);
      tick();
      chk("ill1f_frozen", bus.uaddr, 8'hF8);
      chk("ill1f_sticky", bus.halted, 1);
      chk("ill1f_no_ack", bus.int_ack, 0);
    end
    idle();
    bus.stall = 1;
    rst = 1;
    tick();
    rst = 0;
    bus.stall = 0;
    chk("rst_stall_uaddr", bus.uaddr, 8'hF8);
    chk("rst_stall_halted", bus.halted, 0);
    chk("rst_stall_illegal", bus.illegal, 0);
    bus.opcode = 5'h1E;
    bus.mi_end = 1;
    tick();
    chk("ill1e_halted", bus.halted, 1);
    chk("ill1e_illegal", bus.illegal, 1);
    chk("ill1e_uaddr", bus.uaddr, 8'hF8);
    for (int i = 0; i < 20; i++) begin
      scramble(i + 7);
      tick();
      chk("ill1e_frozen", bus.uaddr, 8'hF8);
      chk("ill1e_sticky", bus.illegal, 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
